// File: rtl/lane_shift_pkg.sv
// Shared types and default geometry for the pipelined lane shifter.
package lane_shift_pkg;

    localparam int LANE_W_DEF  = 5;
    localparam int LANES_DEF   = 10;
    localparam int SHIFT_W_DEF = 4;

    // Lane 0 sits in the low bits, so "right" moves content towards lane 0.
    typedef enum logic [1:0] {
        FILL_R = 2'b00,
        FILL_L = 2'b01,
        ROT_R  = 2'b10,
        ROT_L  = 2'b11
    } shift_mode_t;

    // Everything that travels down the pipeline with a request, at the
    // default geometry. The RTL modules carry the same fields as separate
    // signals sized by their own parameters.
    typedef struct packed {
        logic [LANES_DEF*LANE_W_DEF-1:0] data;
        logic [SHIFT_W_DEF-1:0]          amount;
        shift_mode_t                     mode;
        logic [LANE_W_DEF-1:0]           fill;
        logic                            err;
    } stage_payload_t;

endpackage

// File: rtl/lane_shift_stage.sv
// One registered pipeline stage: shifts by a fixed lane distance when its
// amount bit is set, otherwise passes the word through.
module lane_shift_stage
    import lane_shift_pkg::*;
#(
    parameter int LANE_W    = LANE_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int SHIFT_W   = SHIFT_W_DEF,
    parameter int BIT_IDX   = 0,
    parameter int DIST      = 1,
    parameter int FILL_DIST = 1,
    parameter bit LAST      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [SHIFT_W-1:0]      in_amount,
    input  logic [1:0]              in_mode,
    input  logic [LANE_W-1:0]       in_fill,
    input  logic                    in_err,
    output logic                    out_valid,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [SHIFT_W-1:0]      out_amount,
    output logic [1:0]              out_mode,
    output logic [LANE_W-1:0]       out_fill,
    output logic                    out_err
);

    logic [LANES*LANE_W-1:0] shifted;

    // Per-lane source selection; fill modes use the true distance 2**k,
    // rotate modes use that distance reduced modulo LANES.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        shifted = in_data;
        if (in_amount[BIT_IDX]) begin
            for (int i = 0; i < LANES; i++) begin
                case (shift_mode_t'(in_mode))
                    FILL_R: shifted[i*LANE_W +: LANE_W] = (i + FILL_DIST < LANES)
                        ? in_data[((i + FILL_DIST) % LANES)*LANE_W +: LANE_W] : in_fill;
                    FILL_L: shifted[i*LANE_W +: LANE_W] = (i >= FILL_DIST)
                        ? in_data[((i + LANES - (FILL_DIST % LANES)) % LANES)*LANE_W +: LANE_W]
                        : in_fill;
                    ROT_R:  shifted[i*LANE_W +: LANE_W] =
                        in_data[((i + DIST) % LANES)*LANE_W +: LANE_W];
                    ROT_L:  shifted[i*LANE_W +: LANE_W] =
                        in_data[((i + LANES - DIST) % LANES)*LANE_W +: LANE_W];
                    default: shifted[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
                endcase
            end
        end
        // An out-of-range amount turns the whole result into fill at the output.
        if (LAST && in_err) begin
            shifted = {LANES{in_fill}};
        end
    end

    // Stage register: flush drops the valid bit, a stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_amount <= '0;
            out_mode   <= FILL_R;
            out_fill   <= '0;
            out_err    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (enable) begin
            out_valid  <= in_valid;
            out_data   <= shifted;
            out_amount <= in_amount;
            out_mode   <= in_mode;
            out_fill   <= in_fill;
            out_err    <= in_err;
        end
    end

endmodule

// File: rtl/pipelined_lane_shifter.sv
// Pipelined lane-granular shifter: one stage per shift-amount bit with
// valid/ready flow control, synchronous flush and an in-flight counter.
module pipelined_lane_shifter
    import lane_shift_pkg::*;
#(
    parameter int LANE_W  = LANE_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [SHIFT_W-1:0]      in_shift,
    input  logic [1:0]              in_mode,
    input  logic [LANE_W-1:0]       in_fill,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_err,
    output logic [SHIFT_W:0]        in_flight
);

    localparam int               DATA_W      = LANES * LANE_W;
    localparam logic [SHIFT_W:0] LANES_LIMIT = (SHIFT_W+1)'(LANES);

    logic stall;
    logic accept;
    logic drain;

    // Element k feeds stage k; element SHIFT_W is the output register.
    logic [SHIFT_W:0]   stg_valid;
    logic [SHIFT_W:0]   stg_err;
    logic [DATA_W-1:0]  stg_data   [SHIFT_W+1];
    logic [SHIFT_W-1:0] stg_amount [SHIFT_W+1];
    logic [1:0]         stg_mode   [SHIFT_W+1];
    logic [LANE_W-1:0]  stg_fill   [SHIFT_W+1];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready && !flush;
    assign drain    = out_valid && out_ready;

    assign stg_valid[0]  = in_valid;
    assign stg_data[0]   = in_data;
    assign stg_amount[0] = in_shift;
    assign stg_mode[0]   = in_mode;
    assign stg_fill[0]   = in_fill;
    assign stg_err[0]    = ({1'b0, in_shift} > LANES_LIMIT);

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        lane_shift_stage #(
            .LANE_W   (LANE_W),
            .LANES    (LANES),
            .SHIFT_W  (SHIFT_W),
            .BIT_IDX  (k),
            .DIST     ((2**k) % LANES),
            .FILL_DIST(2**k),
            .LAST     (k == SHIFT_W - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .enable    (!stall),
            .flush     (flush),
            .in_valid  (stg_valid[k]),
            .in_data   (stg_data[k]),
            .in_amount (stg_amount[k]),
            .in_mode   (stg_mode[k]),
            .in_fill   (stg_fill[k]),
            .in_err    (stg_err[k]),
            .out_valid (stg_valid[k+1]),
            .out_data  (stg_data[k+1]),
            .out_amount(stg_amount[k+1]),
            .out_mode  (stg_mode[k+1]),
            .out_fill  (stg_fill[k+1]),
            .out_err   (stg_err[k+1])
        );
    end

    assign out_valid = stg_valid[SHIFT_W];
    assign out_data  = stg_data[SHIFT_W];
    assign out_err   = stg_err[SHIFT_W];

    // Occupancy: up on accept, down on drain, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else if (accept && !drain) begin
            in_flight <= in_flight + (SHIFT_W+1)'(1);
        end else if (drain && !accept) begin
            in_flight <= in_flight - (SHIFT_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_lane_shifter.sv
// Self-checking bench for pipelined_lane_shifter with a queue scoreboard.
module tb_pipelined_lane_shifter;
    import lane_shift_pkg::*;

    localparam int LANE_W  = LANE_W_DEF;
    localparam int LANES   = LANES_DEF;
    localparam int SHIFT_W = SHIFT_W_DEF;
    localparam int DATA_W  = LANES * LANE_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic [1:0]         in_mode;
    logic [LANE_W-1:0]  in_fill;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_err;
    logic [SHIFT_W:0]   in_flight;

    int errors = 0;
    int checks = 0;
    stage_payload_t sb[$];
    int   peak_flight = 0;
    logic track_peak  = 1'b0;

    always #5 clk = ~clk;

    pipelined_lane_shifter #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .SHIFT_W(SHIFT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shift (in_shift),
        .in_mode  (in_mode),
        .in_fill  (in_fill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .in_flight(in_flight)
    );

    // Word whose lane i holds the value i.
    function automatic logic [DATA_W-1:0] ramp_word();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = LANE_W'(i);
        return w;
    endfunction

    // Reference result straight from the lane formulas.
    function automatic stage_payload_t model(input logic [DATA_W-1:0] d, input logic [SHIFT_W-1:0] s,
                                             input logic [1:0] m, input logic [LANE_W-1:0] f);
        stage_payload_t p;
        int s_i;
        int src;
        s_i      = int'(s);
        p.amount = s;
        p.mode   = shift_mode_t'(m);
        p.fill   = f;
        p.err    = (s_i > LANES);
        p.data   = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [LANE_W-1:0] lane;
            lane = f;
            if (!p.err) begin
                case (m)
                    2'b00: if (i + s_i < LANES) lane = d[(i + s_i)*LANE_W +: LANE_W];
                    2'b01: if (i >= s_i) lane = d[(i - s_i)*LANE_W +: LANE_W];
                    2'b10: begin
                        src  = (i + s_i) % LANES;
                        lane = d[src*LANE_W +: LANE_W];
                    end
                    default: begin
                        src  = (i - (s_i % LANES) + LANES) % LANES;
                        lane = d[src*LANE_W +: LANE_W];
                    end
                endcase
            end
            p.data[i*LANE_W +: LANE_W] = lane;
        end
        return p;
    endfunction

    // Scoreboard: every output handshake consumes the oldest expectation.
    always @(negedge clk) begin
        stage_payload_t exp_p;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got data=%h err=%b with nothing pending", out_data, out_err);
            end else begin
                exp_p = sb.pop_front();
                if (out_data !== exp_p.data || out_err !== exp_p.err) begin
                    errors++;
                    $display("FAIL result got data=%h err=%b want data=%h err=%b (shift=%0d mode=%0d)",
                             out_data, out_err, exp_p.data, exp_p.err, exp_p.amount, exp_p.mode);
                end
            end
        end
        if (track_peak && int'(in_flight) > peak_flight) peak_flight = int'(in_flight);
    end

    // Drive one request from posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [DATA_W-1:0] d, input logic [SHIFT_W-1:0] s,
                        input logic [1:0] m, input logic [LANE_W-1:0] f);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        in_mode  = m;
        in_fill  = f;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b after %0d cycles want 1", in_ready, waited);
        end else begin
            sb.push_back(model(d, s, m, f));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty and the pipeline to go idle.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d out_valid=%b want pending=0 out_valid=0", sb.size(), out_valid);
            sb.delete();
        end
        checks++;
        if (in_flight !== '0) begin
            errors++;
            $display("FAIL in_flight_idle got %0d want 0", in_flight);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        if (out_err !== 1'b0)   begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
        if (in_flight !== '0)   begin errors++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int cycles = 0;
        send(ramp_word(), SHIFT_W'(3), FILL_R, LANE_W'(5'h1F));
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 20);
        checks++;
        if (cycles != SHIFT_W || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency got %0d cycles (out_valid=%b) want %0d", cycles, out_valid, SHIFT_W);
        end
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_modes();
        send(ramp_word(), SHIFT_W'(4),  FILL_L, LANE_W'(5'h00));
        send(ramp_word(), SHIFT_W'(7),  ROT_R,  LANE_W'(5'h0A));
        send(ramp_word(), SHIFT_W'(10), ROT_L,  LANE_W'(5'h0A));
        send(ramp_word(), SHIFT_W'(1),  ROT_L,  LANE_W'(5'h0A));
        send(ramp_word(), SHIFT_W'(0),  FILL_R, LANE_W'(5'h1F));
        wait_idle();
    endtask

    task automatic test_range();
        send(ramp_word(), SHIFT_W'(10), FILL_R, LANE_W'(5'h15));
        send(ramp_word(), SHIFT_W'(11), FILL_R, LANE_W'(5'h15));
        send(ramp_word(), SHIFT_W'(15), ROT_L,  LANE_W'(5'h15));
        send(ramp_word(), SHIFT_W'(9),  FILL_L, LANE_W'(5'h15));
        wait_idle();
    endtask

    task automatic test_back_to_back();
        peak_flight = 0;
        track_peak  = 1'b1;
        fork
            begin
                for (int r = 0; r < 8; r++) begin
                    send(DATA_W'({$urandom(), $urandom()}), SHIFT_W'($urandom_range(0, 15)),
                         2'($urandom_range(0, 3)), LANE_W'($urandom_range(0, 31)));
                end
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (!out_valid) begin
                    errors++;
                    $display("FAIL b2b_first_result out_valid=%b after %0d cycles want 1", out_valid, n);
                end else begin
                    @(posedge clk);
                    #1 out_ready = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        checks++;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_in_ready cycle %0d got in_ready=%b out_valid=%b want 0 1",
                                     c, in_ready, out_valid);
                        end
                    end
                    @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            end
        join
        wait_idle();
        track_peak = 1'b0;
        checks++;
        if (peak_flight != SHIFT_W) begin
            errors++;
            $display("FAIL in_flight_peak got %0d want %0d", peak_flight, SHIFT_W);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        send(ramp_word(), SHIFT_W'(1), FILL_R, LANE_W'(5'h03));
        send(ramp_word(), SHIFT_W'(2), ROT_R,  LANE_W'(5'h03));
        send(ramp_word(), SHIFT_W'(3), FILL_L, LANE_W'(5'h03));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = ramp_word();
        in_shift = SHIFT_W'(5);
        in_mode  = ROT_L;
        @(negedge clk);
        checks += 2;
        if (in_flight !== (SHIFT_W+1)'(3)) begin errors++; $display("FAIL pre_flush_in_flight got %0d want 3", in_flight); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (in_flight !== '0) begin errors++; $display("FAIL post_flush_in_flight got %0d want 0", in_flight); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flushed_output got %0d valid cycles want 0", seen); end
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        for (int r = 0; r < 5; r++) send(ramp_word(), SHIFT_W'(r + 2), ROT_R, LANE_W'(5'h07));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_out_valid got %b want 0", out_valid); end
        if (in_flight !== '0)   begin errors++; $display("FAIL async_reset_in_flight got %0d want 0", in_flight); end
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL post_reset_output got %0d valid cycles want 0", seen); end
        @(posedge clk);
        #1;
        test_latency();
    endtask

    // Hard stop in case something upstream of the bounded waits goes wrong.
    initial begin
        #400000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = 2'b00;
        in_fill   = '0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_modes();
        test_range();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
